// File: rtl/exe_stage_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exe_stage_mc                                                    |
// | Brief    : Execute stage with forwarding, 1-cycle ALU, branch target and   |
// |            iterative shift-add multiply; owns the EXE/MEM register.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module exe_stage_mc #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 4,
  parameter int MUL_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [3:0]        exe_cmd,
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic              imm_sel,
  input  logic              s_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              wb_en_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [3:0]        status_in,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DATA_W-1:0] imm_val,
  input  logic [DATA_W-1:0] alu_fwd,
  input  logic [DATA_W-1:0] wb_fwd,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [23:0]       signed_imm_24,
  output logic              stall,
  output logic [DATA_W-1:0] branch_address,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [REG_AW-1:0] dest_out,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en,
  output logic [3:0]        status_out,
  output logic              status_we
);

  localparam int STEPS = DATA_W / MUL_BITS;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS - 1);
  localparam int MSB = DATA_W - 1;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [DATA_W-1:0]   r_m_rm;
  logic [REG_AW-1:0]   r_m_dest;
  logic [1:0]          r_m_cv;
  logic                r_m_s;
  logic                r_m_mr;
  logic                r_m_mw;
  logic                r_m_wb;

  logic [DATA_W-1:0]   w_op1;
  logic [DATA_W-1:0]   w_rm;
  logic [DATA_W-1:0]   w_op2;
  logic [DATA_W-1:0]   w_b;
  logic                w_cin;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_res;
  logic                w_c;
  logic                w_v;
  logic [3:0]          w_flags;
  logic                w_is_mul;
  logic [DATA_W-1:0]   w_pp;
  logic [DATA_W-1:0]   w_mul_res;

  always_comb begin
    case (sel_src1)
      2'b01:   w_op1 = alu_fwd;
      2'b10:   w_op1 = wb_fwd;
      default: w_op1 = val_rn;
    endcase
    case (sel_src2)
      2'b01:   w_rm = alu_fwd;
      2'b10:   w_rm = wb_fwd;
      default: w_rm = val_rm;
    endcase
  end

  assign w_op2    = imm_sel ? imm_val : w_rm;
  assign w_is_mul = (exe_cmd == CMD_MUL);

  // Subtraction is a + ~b + cin, so carry-out is already NOT borrow.
  always_comb begin
    w_b   = ((exe_cmd == CMD_SUB) || (exe_cmd == CMD_SBC)) ? ~w_op2 : w_op2;
    case (exe_cmd)
      CMD_ADD: w_cin = 1'b0;
      CMD_SUB: w_cin = 1'b1;
      default: w_cin = status_in[1];
    endcase
    w_sum = {1'b0, w_op1} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_cin};
  end

  always_comb begin
    w_res = '0;
    w_c   = status_in[1];
    w_v   = status_in[0];
    case (exe_cmd)
      CMD_MOV: w_res = w_op2;
      CMD_MVN: w_res = ~w_op2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_W];
        w_v   = (w_op1[MSB] == w_b[MSB]) && (w_sum[MSB] != w_op1[MSB]);
      end
      CMD_AND: w_res = w_op1 & w_op2;
      CMD_ORR: w_res = w_op1 | w_op2;
      CMD_EOR: w_res = w_op1 ^ w_op2;
      default: w_res = '0;
    endcase
    w_flags = {w_res[MSB], (w_res == '0), w_c, w_v};
  end

  always_comb begin
    w_pp = '0;
    for (int k = 0; k < MUL_BITS; k++) begin
      if (r_mplier[k]) w_pp = w_pp + (r_mcand << k);
    end
  end

  assign w_mul_res = r_acc + w_pp;

  assign stall = !flush &&
                 (((r_state == S_IDLE) && in_valid && w_is_mul) ||
                  ((r_state == S_BUSY) && (r_cnt != '0)));

  assign branch_address = pc_in + DATA_W'($signed({signed_imm_24, 2'b00}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_m_rm     <= '0;
      r_m_dest   <= '0;
      r_m_cv     <= '0;
      r_m_s      <= 1'b0;
      r_m_mr     <= 1'b0;
      r_m_mw     <= 1'b0;
      r_m_wb     <= 1'b0;
      out_valid  <= 1'b0;
      alu_out    <= '0;
      val_rm_out <= '0;
      dest_out   <= '0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      wb_en      <= 1'b0;
      status_out <= '0;
      status_we  <= 1'b0;
    end else if (flush) begin
      r_state   <= S_IDLE;
      out_valid <= 1'b0;
      mem_r_en  <= 1'b0;
      mem_w_en  <= 1'b0;
      wb_en     <= 1'b0;
      status_we <= 1'b0;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_mul_res;
      r_mcand  <= r_mcand << MUL_BITS;
      r_mplier <= r_mplier >> MUL_BITS;
      r_cnt    <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_state    <= S_IDLE;
        out_valid  <= 1'b1;
        alu_out    <= w_mul_res;
        val_rm_out <= r_m_rm;
        dest_out   <= r_m_dest;
        mem_r_en   <= r_m_mr;
        mem_w_en   <= r_m_mw;
        wb_en      <= r_m_wb;
        status_out <= {w_mul_res[MSB], (w_mul_res == '0), r_m_cv};
        status_we  <= r_m_s;
      end
    end else if (in_valid && w_is_mul) begin
      // Operands are latched because forwarding sources move during the stall.
      r_state   <= S_BUSY;
      r_cnt     <= CNT_INIT;
      r_acc     <= '0;
      r_mcand   <= w_op1;
      r_mplier  <= w_op2;
      r_m_rm    <= w_rm;
      r_m_dest  <= dest_in;
      r_m_cv    <= status_in[1:0];
      r_m_s     <= s_in;
      r_m_mr    <= mem_r_en_in;
      r_m_mw    <= mem_w_en_in;
      r_m_wb    <= wb_en_in;
      out_valid <= 1'b0;
      mem_r_en  <= 1'b0;
      mem_w_en  <= 1'b0;
      wb_en     <= 1'b0;
      status_we <= 1'b0;
    end else if (in_valid) begin
      out_valid  <= 1'b1;
      alu_out    <= w_res;
      val_rm_out <= w_rm;
      dest_out   <= dest_in;
      mem_r_en   <= mem_r_en_in;
      mem_w_en   <= mem_w_en_in;
      wb_en      <= wb_en_in;
      status_out <= w_flags;
      status_we  <= s_in;
    end else begin
      out_valid <= 1'b0;
      mem_r_en  <= 1'b0;
      mem_w_en  <= 1'b0;
      wb_en     <= 1'b0;
      status_we <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_exe_stage_mc                                                 |
// | Brief    : Scoreboard bench for exe_stage_mc (MUL_BITS=1 and MUL_BITS=4).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_exe_stage_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, imm_sel, s_in, mem_r_en_in, mem_w_en_in, wb_en_in;
  logic [3:0]  exe_cmd, dest_in, status_in;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] val_rn, val_rm, imm_val, alu_fwd, wb_fwd, pc_in;
  logic [23:0] signed_imm_24;

  logic        stall, out_valid, mem_r_en, mem_w_en, wb_en, status_we;
  logic [31:0] branch_address, alu_out, val_rm_out;
  logic [3:0]  dest_out, status_out;

  logic        stall4, ov4, mr4, mw4, wb4, swe4;
  logic [31:0] br4, alu4, rmo4;
  logic [3:0]  dest4, st4;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rm;
    logic [3:0]  nzcv;
    logic        swe, mr, mw, wb;
    logic [3:0]  dest;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  exe_stage_mc #(.DATA_W(32), .REG_AW(4), .MUL_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .exe_cmd(exe_cmd),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .imm_sel(imm_sel), .s_in(s_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .dest_in(dest_in), .status_in(status_in), .val_rn(val_rn), .val_rm(val_rm),
    .imm_val(imm_val), .alu_fwd(alu_fwd), .wb_fwd(wb_fwd), .pc_in(pc_in),
    .signed_imm_24(signed_imm_24), .stall(stall), .branch_address(branch_address),
    .out_valid(out_valid), .alu_out(alu_out), .val_rm_out(val_rm_out),
    .dest_out(dest_out), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
    .status_out(status_out), .status_we(status_we)
  );

  exe_stage_mc #(.DATA_W(32), .REG_AW(4), .MUL_BITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .exe_cmd(exe_cmd),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .imm_sel(imm_sel), .s_in(s_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .dest_in(dest_in), .status_in(status_in), .val_rn(val_rn), .val_rm(val_rm),
    .imm_val(imm_val), .alu_fwd(alu_fwd), .wb_fwd(wb_fwd), .pc_in(pc_in),
    .signed_imm_24(signed_imm_24), .stall(stall4), .branch_address(br4),
    .out_valid(ov4), .alu_out(alu4), .val_rm_out(rmo4),
    .dest_out(dest4), .mem_r_en(mr4), .mem_w_en(mw4), .wb_en(wb4),
    .status_out(st4), .status_we(swe4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rn,
                                       input logic [31:0] af, input logic [31:0] wf);
    case (s)
      2'b01:   return af;
      2'b10:   return wf;
      default: return rn;
    endcase
  endfunction

  // Reference model: returns {result, N, Z, C, V}.
  function automatic logic [35:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] st);
    logic [31:0] r;
    logic        c, v, ci;
    longint      s;
    r  = '0;
    c  = st[1];
    v  = st[0];
    ci = st[1];
    case (cmd)
      4'b0001: r = b;
      4'b1001: r = ~b;
      4'b0010, 4'b0011: begin
        if (cmd == 4'b0010) ci = 1'b0;
        r = a + b + {31'd0, ci};
        c = (64'(a) + 64'(b) + 64'(ci)) > 64'hFFFF_FFFF;
        s = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0100, 4'b0101: begin
        ci = (cmd == 4'b0100) ? 1'b0 : !st[1];
        r = a - b - {31'd0, ci};
        c = 64'(a) >= (64'(b) + 64'(ci));
        s = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      4'b1010: r = a * b;
      default: r = '0;
    endcase
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  task automatic send(input logic [3:0] cmd, input logic [1:0] s1, input logic [1:0] s2,
                      input logic imm, input logic s, input logic [2:0] ctl,
                      input logic [3:0] dst, input logic [3:0] st,
                      input logic [31:0] rn, input logic [31:0] rm, input logic [31:0] iv,
                      input logic [31:0] af, input logic [31:0] wf,
                      input bit push, output bit stall_seen);
    logic [31:0] op1, rmv, op2;
    logic [35:0] m;
    exp_t        x;
    exe_cmd = cmd; sel_src1 = s1; sel_src2 = s2; imm_sel = imm; s_in = s;
    {mem_r_en_in, mem_w_en_in, wb_en_in} = ctl; dest_in = dst; status_in = st;
    val_rn = rn; val_rm = rm; imm_val = iv; alu_fwd = af; wb_fwd = wf;
    in_valid = 1'b1;
    op1 = pick(s1, rn, af, wf);
    rmv = pick(s2, rm, af, wf);
    op2 = imm ? iv : rmv;
    m   = model(cmd, op1, op2, st);
    x   = '{alu: m[35:4], rm: rmv, nzcv: m[3:0], swe: s, mr: ctl[2], mw: ctl[1],
            wb: ctl[0], dest: dst};
    if (push) sb.push_back(x);
    last_res = m[35:4];
    #1 stall_seen = stall;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sb_alu", alu_out, e.alu);
          check("sb_flags", status_out, e.nzcv);
          check("sb_rm", val_rm_out, e.rm);
          check("sb_ctl", {status_we, mem_r_en, mem_w_en, wb_en, dest_out},
                {e.swe, e.mr, e.mw, e.wb, e.dest});
        end
      end else begin
        check("bubble_ctl", {status_we, mem_r_en, mem_w_en, wb_en}, 4'b0000);
      end
    end
  end

  initial begin
    bit          sst;
    int          n_stall, lat, lat4;
    logic [3:0]  cmds [11];
    cmds = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
             4'b0110, 4'b0111, 4'b1000, 4'b0000, 4'b1111};
    rst = 1'b1; in_valid = 0; flush = 0; exe_cmd = 0; sel_src1 = 0; sel_src2 = 0;
    imm_sel = 0; s_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0;
    dest_in = 0; status_in = 0; val_rn = 0; val_rm = 0; imm_val = 0; alu_fwd = 0;
    wb_fwd = 0; pc_in = 0; signed_imm_24 = 0; last_res = 0;
    #2;
    check("rst_out", {out_valid, stall, status_we, mem_r_en, mem_w_en, wb_en}, 6'b0);
    check("rst_data", {alu_out, val_rm_out, dest_out, status_out}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Branch target
    pc_in = 32'h100; signed_imm_24 = 24'hFFFFFF;
    #1 check("br_neg", branch_address, 32'hFC);
    check("br_neg4", br4, 32'hFC);
    signed_imm_24 = 24'h000010;
    #1 check("br_pos", branch_address, 32'h140);

    // Overflowing ADD
    send(4'b0010, 2'b00, 2'b00, 0, 1, 3'b001, 4'd1, 4'b0000,
         32'h7FFFFFFF, 32'h1, 0, 0, 0, 1, sst);
    check("add_ovf_res", alu_out, 32'h80000000);
    check("add_ovf_flags", {status_out, status_we}, {4'b1001, 1'b1});
    // SUB with Rn taken from the ALU forward path
    send(4'b0100, 2'b01, 2'b00, 0, 1, 3'b001, 4'd2, 4'b0000,
         32'd9, 32'd5, 0, 32'd5, 0, 1, sst);
    check("sub_fwd_res", alu_out, 32'd0);
    check("sub_fwd_flags", status_out, 4'b0110);

    send(4'b1001, 2'b00, 2'b10, 0, 1, 3'b100, 4'd3, 4'b0000, 0, 0, 0, 0, 32'h0F0F, 1, sst);
    send(4'b0011, 2'b11, 2'b00, 1, 1, 3'b010, 4'd4, 4'b0010,
         32'hFFFFFFFF, 32'h5A, 32'd0, 32'h77, 0, 1, sst);
    send(4'b0101, 2'b10, 2'b01, 0, 1, 3'b001, 4'd5, 4'b0000,
         0, 0, 0, 32'd3, 32'd3, 1, sst);
    send(4'b0100, 2'b00, 2'b00, 0, 1, 3'b001, 4'd6, 4'b0000,
         32'h80000000, 32'd1, 0, 0, 0, 1, sst);
    send(4'b0110, 2'b00, 2'b00, 0, 0, 3'b111, 4'd7, 4'b0011,
         32'hF0F0_1234, 32'hFF00_FF00, 0, 0, 0, 1, sst);
    send(4'b0000, 2'b00, 2'b00, 0, 1, 3'b001, 4'd8, 4'b1111, 32'd4, 32'd4, 0, 0, 0, 1, sst);
    @(posedge clk);
    #1 check("bubble_hold", {out_valid, alu_out}, {1'b0, last_res});

    for (int i = 0; i < 20; i++) begin
      send(cmds[$urandom_range(0, 10)], 2'($urandom), 2'($urandom), 1'($urandom),
           1'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), $urandom, $urandom,
           $urandom, $urandom, $urandom, 1, sst);
    end

    // MUL 7 x 6 with Rn from alu_fwd, which is then disturbed mid-operation
    send(4'b1010, 2'b01, 2'b00, 0, 1, 3'b001, 4'd9, 4'b0011,
         32'd1, 32'd6, 0, 32'd7, 0, 1, sst);
    check("mul_issue_stall", sst, 1);
    alu_fwd = 32'h55; val_rm = 32'd9; status_in = 4'b0000;
    n_stall = sst ? 1 : 0; lat = -1; lat4 = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      if (stall) n_stall++;
      @(posedge clk);
      #1;
      if (out_valid) lat = k;
      if (ov4 && lat4 < 0) begin
        lat4 = k;
        check("mul4_res", alu4, 32'd42);
      end
    end
    check("mul_latency", lat + 1, 33);
    check("mul_stall_cycles", n_stall, 32);
    check("mul4_latency", lat4 + 1, 9);
    check("mul_res", alu_out, 32'd42);

    // MUL flushed at its fifth BUSY cycle
    send(4'b1010, 2'b00, 2'b00, 0, 1, 3'b001, 4'd10, 4'b0000, 32'd3, 32'd4, 0, 0, 0, 0, sst);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    #1 check("flush_stall", stall, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_after", {out_valid, stall}, 2'b00);
    repeat (30) @(posedge clk);
    #1;
    send(4'b0010, 2'b00, 2'b00, 0, 1, 3'b001, 4'd11, 4'b0000, 32'd20, 32'd22, 0, 0, 0, 1, sst);
    check("add_after_flush", alu_out, 32'd42);

    // Asynchronous reset while BUSY
    send(4'b1010, 2'b00, 2'b00, 0, 1, 3'b001, 4'd12, 4'b0000, 32'd5, 32'd5, 0, 0, 0, 0, sst);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_busy_ctl", {out_valid, stall, stall4, wb_en, status_we}, 5'b0);
    check("rst_busy_data", {alu_out, status_out, dest_out}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("rst_idle", {out_valid, stall}, 2'b00);
    check("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
Parametrised execute stage for the pipelined ARM-subset core. It performs operand forwarding, single-cycle ALU operations, branch-target generation and a new iterative multi-cycle multiply (MUL). The block owns the EXE/MEM pipeline register. It stalls upstream while a multiply is in flight and accepts a flush from the hazard/branch logic.

Parameters:
DATA_W, 32, datapath width (≥8)
REG_AW, 4, register-index width for the destination tag
MUL_BITS, 1, multiplier bits retired per cycle (1, 2 or 4; must divide DATA_W)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  ID/EXE register holds a valid instruction
flush  in  1  kill instruction in EXE (including an in-flight MUL) and bubble output
exe_cmd  in  4  0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR, 1010 MUL; others are a NOP result of 0
sel_src1  in  2  forwarding select for Rn: 00 val_rn, 01 alu_fwd, 10 wb_fwd, 11 val_rn
sel_src2  in  2  forwarding select for Rm, same encoding
imm_sel  in  1  op2 = imm_val instead of forwarded Rm
s_in  in  1  update flags
mem_r_en_in / mem_w_en_in / wb_en_in  in  1 each  control passthrough
dest_in  in  REG_AW  destination register tag
status_in  in  4  current {N,Z,C,V}
val_rn, val_rm, imm_val, alu_fwd, wb_fwd, pc_in  in  DATA_W  operands and forwarding sources
signed_imm_24  in  24  branch offset
stall  out  1  hold IF/ID/ID-EXE registers this cycle
branch_address  out  DATA_W  combinational pc_in + sext(signed_imm_24)<<2, truncated to DATA_W
out_valid  out  1  EXE/MEM register holds a valid instruction
alu_out, val_rm_out  out  DATA_W  registered result and forwarded Rm for stores
dest_out  out  REG_AW  registered destination tag
mem_r_en, mem_w_en, wb_en  out  1  registered controls, forced to 0 when out_valid=0
status_out  out  4  registered {N,Z,C,V}
status_we  out  1  registered; equals s_in & valid-commit

Behaviour:
- Reset (async): state IDLE; every registered output is 0; stall is 0.
- IDLE, non-MUL, in_valid=1: compute the result combinationally. On the next clk edge load the EXE/MEM register and set out_valid=1. Latency is 1 cycle and stall=0.
- Arithmetic: ADD/SUB/ADC/SBC compute at DATA_W+1 bits. C is the carry-out (SUB/SBC carry = NOT borrow, with SBC = a−b−!C). V is signed overflow. Logic ops and MOV/MVN pass C and V from status_in. N is bit DATA_W−1 of the result; Z means the result is 0.
- MUL, IDLE, in_valid=1: capture the forwarded operands into internal registers at that edge, because forwarding sources may change while stalled. Enter BUSY with counter = DATA_W/MUL_BITS − 1.
  - stall=1 combinationally from the issue cycle until the final BUSY cycle.
  - out_valid=0 while BUSY.
  - Each BUSY cycle adds the partial product of MUL_BITS multiplier bits. The result is the low DATA_W bits of the product.
  - When the counter reaches 0, stall drops, the EXE/MEM register loads the result with out_valid=1, and the state returns to IDLE.
  - Total latency is DATA_W/MUL_BITS + 1 cycles from issue to out_valid.
  - Flags: N and Z from the result; C and V from status_in as captured at issue.
- flush: the next edge clears out_valid and all enables. A BUSY multiply is aborted and returns to IDLE; stall is 0 in the flush cycle. flush takes priority over issue and completion in the same cycle.
- in_valid=0 in IDLE: bubble, so out_valid=0 and the enables are 0. alu_out holds its previous value.
- Forwarding select 11 is treated as 00.
- val_rm_out is forwarded Rm and ignores imm_sel.
- Reset during BUSY returns to IDLE immediately, with no output.

Test Plan:
1. DATA_W=32: ADD 0x7FFFFFFF+1, s_in=1 -> one cycle later alu_out=0x80000000, status_out N=1 Z=0 C=0 V=1, status_we=1.
2. SUB 5−5 with sel_src1=01, alu_fwd=5, val_rn=9 -> alu_out=0, Z=1, C=1, proving the forwarding path is used.
3. MUL 7×6, MUL_BITS=1 -> stall high for 32 cycles, out_valid=0 until cycle 33, then alu_out=42. Change alu_fwd mid-operation -> result unchanged.
4. MUL issued, flush at BUSY cycle 5 -> next edge out_valid=0, stall=0, state IDLE; a following ADD completes normally.
5. Branch: pc_in=0x100, signed_imm_24=0xFFFFFF -> branch_address=0xFC. Offset 0x000010 -> 0x140.
6. Assert rst during BUSY -> all outputs 0 and stall 0 without a clock edge. MUL_BITS=4 rerun of case 3 completes in 9 cycles.
